// File: rtl/secure_mem_ctrl_if.sv
// Request/response channel of the key-gated storage controller.
// The master issues keyed read/write requests; the slave answers with one response each.
interface secure_mem_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int KEY_W  = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [KEY_W-1:0]  req_key;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_key, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_key, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/secure_mem_ctrl.sv
// Key-gated word storage with an address/key keystream scramble and a
// consecutive-failure lockout.
module secure_mem_ctrl #(
  parameter int              DATA_W      = 32,
  parameter int              ADDR_W      = 10,
  parameter int              DEPTH       = 1024,
  parameter int              KEY_W       = 16,
  parameter logic [KEY_W-1:0] KEY_RST    = 16'hA5C3,
  parameter int              MAX_FAIL    = 3,
  parameter int              LOCK_CYCLES = 256
) (
  input  logic                             clk,
  input  logic                             rst_n,
  secure_mem_ctrl_if.slave                 bus,
  input  logic                             key_load,
  input  logic [KEY_W-1:0]                 key_in,
  output logic                             locked,
  output logic [$clog2(MAX_FAIL+1)-1:0]    fail_cnt
);

  localparam int FC_W   = $clog2(MAX_FAIL + 1);
  localparam int LK_W   = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RATIO  = DATA_W / KEY_W;
  localparam logic [ADDR_W:0]  DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [FC_W-1:0]  FAIL_MAX  = FC_W'(MAX_FAIL);
  localparam logic [LK_W-1:0]  LOCK_LOAD = LK_W'(LOCK_CYCLES - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CHECK  = 3'd1;
  localparam logic [2:0] ACCESS = 3'd2;
  localparam logic [2:0] RESP   = 3'd3;
  localparam logic [2:0] LOCKED = 3'd4;

  logic [2:0]        state;
  logic [KEY_W-1:0]  key_reg;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [KEY_W-1:0]  key_q;
  logic              err_q;
  logic              rd_ok;
  logic [LK_W-1:0]   lock_cnt;
  logic [DATA_W-1:0] mem_rd;
  logic [DATA_W-1:0] ks;
  logic              addr_oob;
  logic              accept;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // The keystream is built from the key latched with the request, which equals
  // the stored key whenever the memory is actually touched.
  assign ks       = {RATIO{key_q}} ^ DATA_W'(addr_q);
  assign addr_oob = {1'b0, addr_q} >= DEPTH_L;
  assign accept   = bus.req_valid && bus.req_ready;

  assign bus.req_ready = (state == IDLE) && !key_load;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_err   = (state == RESP) && err_q;
  assign bus.rsp_rdata = ((state == RESP) && rd_ok) ? (mem_rd ^ ks) : '0;
  assign locked        = (state == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      key_reg  <= KEY_RST;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      key_q    <= '0;
      err_q    <= 1'b0;
      rd_ok    <= 1'b0;
      lock_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_load) begin
            key_reg <= key_in;
          end else if (accept) begin
            wr_q    <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            key_q   <= bus.req_key;
            state   <= CHECK;
          end
        end
        // Range is checked before the key so a bad address never counts as a key failure.
        CHECK: begin
          if (addr_oob) begin
            err_q <= 1'b1;
            rd_ok <= 1'b0;
            state <= RESP;
          end else if (key_q != key_reg) begin
            err_q <= 1'b1;
            rd_ok <= 1'b0;
            if (fail_cnt != FAIL_MAX) begin
              fail_cnt <= fail_cnt + FC_W'(1);
            end
            state <= RESP;
          end else begin
            state <= ACCESS;
          end
        end
        ACCESS: begin
          fail_cnt <= '0;
          err_q    <= 1'b0;
          rd_ok    <= !wr_q;
          state    <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            if (fail_cnt == FAIL_MAX) begin
              lock_cnt <= LOCK_LOAD;
              state    <= LOCKED;
            end else begin
              state <= IDLE;
            end
          end
        end
        LOCKED: begin
          if (lock_cnt == '0) begin
            fail_cnt <= '0;
            state    <= IDLE;
          end else begin
            lock_cnt <= lock_cnt - LK_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array port kept free of reset and output logic so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (state == ACCESS) begin
      if (wr_q) begin
        mem[addr_q[MEM_AW-1:0]] <= wdata_q ^ ks;
      end else begin
        mem_rd <= mem[addr_q[MEM_AW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_secure_mem_ctrl.sv
// Directed scoreboard bench for secure_mem_ctrl: expected responses are queued
// at issue time and checked by an independent response monitor.
module tb_secure_mem_ctrl;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       tag;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        key_load;
  logic [15:0] key_in;
  logic        locked;
  logic [1:0]  fail_cnt;

  int   checks;
  int   errors;
  exp_t sb[$];

  secure_mem_ctrl_if #(.DATA_W(32), .ADDR_W(10), .KEY_W(16)) bus ();

  secure_mem_ctrl #(
    .DATA_W(32), .ADDR_W(10), .DEPTH(512), .KEY_W(16),
    .KEY_RST(16'hA5C3), .MAX_FAIL(3), .LOCK_CYCLES(256)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .key_load (key_load),
    .key_in   (key_in),
    .locked   (locked),
    .fail_cnt (fail_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s timed out", name);
  endtask

  // Monitor: every consumed response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        timeoutFail("unexpected_response");
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput({e.tag, "_rdata"}, bus.rsp_rdata, e.rdata);
        checkOutput({e.tag, "_err"}, {31'b0, bus.rsp_err}, {31'b0, e.err});
      end
    end
  end

  task automatic applyStimulus(input logic wr, input logic [9:0] addr, input logic [31:0] wdata,
                               input logic [15:0] key, input logic [31:0] exp_rdata,
                               input logic exp_err, input string tag);
    bit ok;
    exp_t e;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.tag   = tag;
    sb.push_back(e);
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_key   = key;
    bus.req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready) ok = 1'b1;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    if (!ok) timeoutFail({tag, "_accept"});
  endtask

  task automatic waitResponse(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.rsp_valid && bus.rsp_ready) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!ok) timeoutFail({tag, "_response"});
  endtask

  initial begin
    int  n;
    bit  stable;
    bit  rdy_low;
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    key_load      = 1'b0;
    key_in        = '0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_key   = '0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    checkOutput("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    checkOutput("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    checkOutput("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    checkOutput("rst_locked", {31'b0, locked}, 32'd0);
    checkOutput("rst_fail_cnt", {30'b0, fail_cnt}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Write then read back, including response latency and raw stored word.
    applyStimulus(1'b1, 10'h005, 32'hDEADBEEF, 16'hA5C3, 32'h0, 1'b0, "wr5");
    waitResponse("wr5");
    checkOutput("raw_word5", dut.mem[5], 32'h7B6E1B29);

    applyStimulus(1'b0, 10'h005, 32'h0, 16'hA5C3, 32'hDEADBEEF, 1'b0, "rd5");
    repeat (2) @(negedge clk);
    checkOutput("latency_edge2_valid", {31'b0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    checkOutput("latency_edge3_valid", {31'b0, bus.rsp_valid}, 32'd1);
    @(posedge clk);
    #1;

    // Backpressure: response held for 10 cycles, outputs frozen.
    bus.rsp_ready = 1'b0;
    applyStimulus(1'b0, 10'h005, 32'h0, 16'hA5C3, 32'hDEADBEEF, 1'b0, "bp_rd5");
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    stable  = 1'b1;
    rdy_low = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_rdata !== 32'hDEADBEEF || bus.rsp_err !== 1'b0) stable = 1'b0;
      if (bus.req_ready !== 1'b0) rdy_low = 1'b0;
    end
    checkOutput("bp_outputs_stable", {31'b0, stable}, 32'd1);
    checkOutput("bp_req_ready_low", {31'b0, rdy_low}, 32'd1);
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    waitResponse("bp_rd5");

    // Two bad keys then a good one: counter climbs then clears, no lockout.
    applyStimulus(1'b0, 10'h005, 32'h0, 16'h0000, 32'h0, 1'b1, "bad_a1");
    waitResponse("bad_a1");
    checkOutput("bad_a1_fail_cnt", {30'b0, fail_cnt}, 32'd1);
    applyStimulus(1'b0, 10'h005, 32'h0, 16'h0000, 32'h0, 1'b1, "bad_a2");
    waitResponse("bad_a2");
    checkOutput("bad_a2_fail_cnt", {30'b0, fail_cnt}, 32'd2);
    applyStimulus(1'b0, 10'h005, 32'h0, 16'hA5C3, 32'hDEADBEEF, 1'b0, "good_a3");
    waitResponse("good_a3");
    checkOutput("good_a3_fail_cnt", {30'b0, fail_cnt}, 32'd0);
    checkOutput("good_a3_locked", {31'b0, locked}, 32'd0);

    // Three bad keys: lockout for exactly 256 cycles.
    applyStimulus(1'b0, 10'h005, 32'h0, 16'h0000, 32'h0, 1'b1, "lk1");
    waitResponse("lk1");
    checkOutput("lk1_fail_cnt", {30'b0, fail_cnt}, 32'd1);
    applyStimulus(1'b0, 10'h005, 32'h0, 16'h0000, 32'h0, 1'b1, "lk2");
    waitResponse("lk2");
    checkOutput("lk2_fail_cnt", {30'b0, fail_cnt}, 32'd2);
    applyStimulus(1'b0, 10'h005, 32'h0, 16'h0000, 32'h0, 1'b1, "lk3");
    waitResponse("lk3");
    checkOutput("lk3_fail_cnt", {30'b0, fail_cnt}, 32'd3);
    checkOutput("lk3_locked", {31'b0, locked}, 32'd1);
    n       = 0;
    rdy_low = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!locked) break;
      n++;
      if (bus.req_ready !== 1'b0) rdy_low = 1'b0;
    end
    checkOutput("lock_cycles", n, 32'd256);
    checkOutput("lock_req_ready_low", {31'b0, rdy_low}, 32'd1);
    checkOutput("unlock_fail_cnt", {30'b0, fail_cnt}, 32'd0);
    checkOutput("unlock_req_ready", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Key load collides with a request: load wins, request retried with new key.
    key_load      = 1'b1;
    key_in        = 16'h1234;
    bus.req_write = 1'b0;
    bus.req_addr  = 10'h005;
    bus.req_key   = 16'h1234;
    bus.req_valid = 1'b1;
    begin
      exp_t e;
      e.rdata = 32'h695A0918;
      e.err   = 1'b0;
      e.tag   = "kl_rd5";
      sb.push_back(e);
    end
    @(negedge clk);
    checkOutput("kl_req_ready_stall", {31'b0, bus.req_ready}, 32'd0);
    @(posedge clk);
    #1 key_load = 1'b0;
    @(negedge clk);
    checkOutput("kl_req_ready_retry", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    waitResponse("kl_rd5");

    applyStimulus(1'b0, 10'h005, 32'h0, 16'hA5C3, 32'h0, 1'b1, "old_key");
    waitResponse("old_key");
    checkOutput("old_key_fail_cnt", {30'b0, fail_cnt}, 32'd1);

    // Out-of-range write is rejected without touching the failure counter.
    applyStimulus(1'b1, 10'h200, 32'hCAFEF00D, 16'h1234, 32'h0, 1'b1, "oob_wr");
    waitResponse("oob_wr");
    checkOutput("oob_fail_cnt", {30'b0, fail_cnt}, 32'd1);

    applyStimulus(1'b0, 10'h005, 32'h0, 16'h1234, 32'h695A0918, 1'b0, "new_key_rd5");
    waitResponse("new_key_rd5");
    checkOutput("new_key_fail_cnt", {30'b0, fail_cnt}, 32'd0);

    // Reset while a write sits in ACCESS: write dropped, key reverts.
    applyStimulus(1'b1, 10'h007, 32'h11111111, 16'h1234, 32'h0, 1'b0, "wr7");
    waitResponse("wr7");
    bus.req_write = 1'b1;
    bus.req_addr  = 10'h007;
    bus.req_wdata = 32'h22222222;
    bus.req_key   = 16'h1234;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    checkOutput("mid_rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    checkOutput("mid_rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    checkOutput("mid_rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    checkOutput("mid_rst_locked", {31'b0, locked}, 32'd0);
    checkOutput("mid_rst_fail_cnt", {30'b0, fail_cnt}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1'b0, 10'h007, 32'h0, 16'hA5C3, 32'hA6E6A6E6, 1'b0, "post_rst_rd7");
    waitResponse("post_rst_rd7");

    repeat (2) @(posedge clk);
    checkOutput("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
